// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory and buffers up to two returned instructions for IF/ID.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hazard_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        addr_err
);

  logic [31:0] fetch_pc;
  logic [1:0]  out_cnt;
  logic [1:0]  drop_cnt;
  logic [1:0]  occ;
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_inst [2];

  logic        pop;
  logic        accept;
  logic        push;
  logic        wr_idx;
  logic [2:0]  credit_use;
  logic [1:0]  out_cnt_nxt;
  logic [31:0] resp_pc;

  assign inst_valid = (occ != 2'd0);
  assign pc         = inst_valid ? buf_pc[0] : 32'h0;
  assign inst       = inst_valid ? buf_inst[0] : 32'h0;

  assign pop        = inst_valid & ~hazard_stall & ~redirect;
  assign credit_use = {1'b0, out_cnt} + {1'b0, occ} - {2'b00, pop};
  assign imem_req   = resetn & ~addr_err & (credit_use < 3'd2);
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req & imem_ack;

  assign push        = imem_rvalid & (drop_cnt == 2'd0) & ~redirect;
  assign out_cnt_nxt = out_cnt + {1'b0, accept} - {1'b0, imem_rvalid};

  // Live requests are consecutive words ending at fetch_pc-4, so the oldest
  // one (the next to return once drops have drained) sits out_cnt words back.
  assign resp_pc = fetch_pc - {28'h0, out_cnt, 2'b00};

  // Slot for the incoming word after this cycle's pop shifts the head.
  assign wr_idx = (occ == 2'd2) | ((occ == 2'd1) & ~pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      out_cnt  <= 2'd0;
      drop_cnt <= 2'd0;
      occ      <= 2'd0;
      addr_err <= 1'b0;
    end else begin
      out_cnt <= out_cnt_nxt;
      if (redirect) begin
        occ      <= 2'd0;
        drop_cnt <= out_cnt_nxt;
        fetch_pc <= redirect_pc;
        addr_err <= (redirect_pc[1:0] != 2'b00);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_rvalid && (drop_cnt != 2'd0)) begin
          drop_cnt <= drop_cnt - 2'd1;
        end
        occ <= occ + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      buf_pc[0]   <= buf_pc[1];
      buf_inst[0] <= buf_inst[1];
    end
    if (push) begin
      buf_pc[wr_idx]   <= resp_pc;
      buf_inst[wr_idx] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: an in-order memory model plus a transaction-level
// reference of the fetch queue, driven by directed and random steps.
module tb_ifetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, hazard_stall, redirect, imem_ack, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid, addr_err;
  logic [31:0] imem_addr, pc, inst;

  logic        hi_resetn, hi_ack, hi_rvalid;
  logic        hi_req, hi_valid, hi_err;
  logic [31:0] hi_addr, hi_pc, hi_inst;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .resetn(resetn), .hazard_stall(hazard_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .addr_err(addr_err)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .resetn(hi_resetn), .hazard_stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ack(hi_ack), .imem_rvalid(hi_rvalid), .imem_rdata(32'hCAFE_0001),
    .pc(hi_pc), .inst(hi_inst), .inst_valid(hi_valid), .addr_err(hi_err)
  );

  typedef struct { logic [31:0] pc; logic [31:0] maddr; bit drop; int ready; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  pend_t       pend_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc;
  bit          m_err;
  int          cyc, checks, failures, ack_pct, lat_min, lat_max;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: memory drives its side, outputs are compared against the
  // reference, then both memory and reference advance on the edge.
  task automatic cycle();
    bit          pop, e_req, acc;
    logic [31:0] seen_addr, e_pc, e_inst;
    pend_t       p;
    imem_ack = ($urandom_range(99) < ack_pct);
    if (resetn && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(pend_q[0].maddr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    pop   = fifo_q.size() > 0 && !hazard_stall && !redirect;
    e_req = resetn && !m_err && (pend_q.size() + fifo_q.size() - int'(pop) < 2);
    if (fifo_q.size() > 0) begin
      e_pc   = fifo_q[0].pc;
      e_inst = fifo_q[0].inst;
    end else begin
      e_pc   = 32'h0;
      e_inst = 32'h0;
    end
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(fifo_q.size() > 0));
    chk("pc", pc, e_pc);
    chk("inst", inst, e_inst);
    chk("addr_err", 32'(addr_err), 32'(m_err));
    acc       = e_req && imem_ack;
    seen_addr = imem_addr;
    @(posedge clk);
    if (!resetn) begin
      pend_q.delete();
      fifo_q.delete();
      m_pc  = 32'h0;
      m_err = 1'b0;
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (imem_rvalid) begin
        p = pend_q.pop_front();
        if (!p.drop && !redirect) fifo_q.push_back(ent_t'{pc: p.pc, inst: mem_data(p.pc)});
      end
      if (acc) begin
        pend_q.push_back(pend_t'{pc: m_pc, maddr: seen_addr, drop: 1'b0,
                                 ready: cyc + int'($urandom_range(lat_max, lat_min))});
        m_pc = m_pc + 32'd4;
      end
      if (redirect) begin
        fifo_q.delete();
        foreach (pend_q[i]) pend_q[i].drop = 1'b1;
        m_pc  = redirect_pc;
        m_err = (redirect_pc[1:0] != 2'b00);
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    bit found;
    checks = 0; failures = 0; cyc = 0;
    resetn = 1'b0; hazard_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    hi_resetn = 1'b0; hi_ack = 1'b0; hi_rvalid = 1'b0;
    ack_pct = 100; lat_min = 1; lat_max = 1;
    m_pc = 32'h0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then single-cycle memory streaming
    cycle();
    resetn = 1'b1;
    repeat (10) cycle();

    // stall with a full buffer, then drain
    hazard_stall = 1'b1;
    repeat (4) cycle();
    hazard_stall = 1'b0;
    repeat (6) cycle();

    // 3-cycle memory, redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pend_q.size() == 2) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (!found) begin
      failures++;
      $display("FAIL wait_two_outstanding got=%0d exp=2", pend_q.size());
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    repeat (10) cycle();

    // redirect coinciding with an accept and a response
    lat_min = 1; lat_max = 1;
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pend_q.size() == 1 && fifo_q.size() == 0 && pend_q[0].ready <= cyc) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (!found) begin
      failures++;
      $display("FAIL wait_ack_rvalid got=%0d exp=1", pend_q.size());
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();

    // misaligned redirect, then recovery
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cycle();
    redirect = 1'b0;
    repeat (6) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();

    // reset mid-stream
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    repeat (4) cycle();

    // random traffic
    lat_min = 1; lat_max = 4;
    for (int n = 0; n < 800; n++) begin
      ack_pct      = 60 + int'($urandom_range(40));
      hazard_stall = ($urandom_range(99) < 25);
      redirect     = ($urandom_range(99) < 6);
      redirect_pc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) redirect_pc = 32'hFFFF_FFF4;
      if ($urandom_range(9) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
      resetn       = ($urandom_range(199) != 0);
      cycle();
    end
    resetn = 1'b1; redirect = 1'b0; hazard_stall = 1'b0;
    repeat (4) cycle();

    // non-zero reset PC: wrap-around and reset mid-stream
    hi_resetn = 1'b0;
    @(posedge clk); #2;
    chk("hi_rst_req", 32'(hi_req), 32'h0);
    chk("hi_rst_addr", hi_addr, 32'hFFFF_FFF8);
    chk("hi_rst_valid", 32'(hi_valid), 32'h0);
    chk("hi_rst_pc", hi_pc, 32'h0);
    chk("hi_rst_err", 32'(hi_err), 32'h0);
    hi_resetn = 1'b1; hi_ack = 1'b1;
    #1;
    chk("hi_req0", 32'(hi_req), 32'h1);
    chk("hi_addr0", hi_addr, 32'hFFFF_FFF8);
    @(posedge clk); #2;
    chk("hi_req1", 32'(hi_req), 32'h1);
    chk("hi_addr1", hi_addr, 32'hFFFF_FFFC);
    hi_rvalid = 1'b1;
    @(posedge clk); #2;
    hi_rvalid = 1'b0; hi_ack = 1'b0;
    #1;
    chk("hi_addr2", hi_addr, 32'h0000_0000);
    chk("hi_valid2", 32'(hi_valid), 32'h1);
    chk("hi_pc2", hi_pc, 32'hFFFF_FFF8);
    chk("hi_inst2", hi_inst, 32'hCAFE_0001);
    chk("hi_req2", 32'(hi_req), 32'h1);
    hi_resetn = 1'b0;
    @(posedge clk); #2;
    chk("hi_mid_valid", 32'(hi_valid), 32'h0);
    chk("hi_mid_req", 32'(hi_req), 32'h0);
    chk("hi_mid_pc", hi_pc, 32'h0);
    chk("hi_mid_addr", hi_addr, 32'hFFFF_FFF8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues in-order word requests to instruction memory over a req/ack + rvalid handshake, and buffers up to two returned instructions in a 2-entry FIFO. Presents `{pc, inst, inst_valid}` to IF/ID, honours the shared `hazard_stall`, and discards in-flight fetches on a branch/jump redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `hazard_stall`  in  1  downstream stall; output entry is held, not consumed.
- `redirect`  in  1  branch/jump taken; flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32  new fetch address, sampled when `redirect`=1.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address (equals fetch PC).
- `imem_ack`  in  1  request accepted this cycle (when `imem_req`=1).
- `imem_rvalid`  in  1  read data valid; responses are in request order.
- `imem_rdata`  in  32  returned instruction word.
- `pc`  out  32  PC of the instruction presented to IF/ID.
- `inst`  out  32  instruction presented; 32'h0 (NOP) when `inst_valid`=0.
- `inst_valid`  out  1  `pc`/`inst` hold a real fetched instruction.
- `addr_err`  out  1  sticky misaligned-redirect flag.

## Operation
- State: `fetch_pc`[31:0], outstanding count `out_cnt` (0–2), drop count `drop_cnt` (0–2), FIFO of 2 × {pc, inst} with occupancy `occ` (0–2), `addr_err`.
- Pop = `inst_valid` & ~`hazard_stall` & ~`redirect`.
- `imem_req` = ~`addr_err` & (`out_cnt` + `occ` − pop < 2); `imem_addr` = `fetch_pc`. Combinational from state and pop.
- Accept = `imem_req` & `imem_ack`: `out_cnt`+1; `fetch_pc` ← `fetch_pc`+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0). A FIFO entry's pc equals the `imem_addr` of its request.
- Response (`imem_rvalid`): `out_cnt`−1. If `drop_cnt`>0, discard and decrement `drop_cnt`; else push {pc, `imem_rdata`}. Push and pop in the same cycle keep `occ` unchanged.
- Outputs: FIFO head when `occ`>0 (`inst_valid`=1); else `pc`=0, `inst`=0, `inst_valid`=0. Held stable while `hazard_stall`=1.
- Redirect (priority over all else): FIFO cleared (`occ`←0); `drop_cnt` ← `out_cnt` after this cycle's accept and response; `fetch_pc` ← `redirect_pc`. An accept in the same cycle is dropped. An `rvalid` in the same cycle is discarded.
- If `redirect_pc`[1:0]≠0: `addr_err`←1, no requests issued. `addr_err` clears only on an aligned redirect or reset. Pending drops still drain.
- `hazard_stall` during redirect: the redirect still flushes.

## Timing
- Reset (`resetn`=0 at edge): `fetch_pc`←`RESET_PC`; all counters and `occ` ←0; `addr_err`←0. While `resetn`=0, `imem_req`=0. After reset: `pc`=0, `inst`=0, `inst_valid`=0.
- First `imem_req` in the first cycle with `resetn`=1.
- Reset mid-operation: all outstanding responses are forgotten. Memory must be reset with the core.
- Latency: accept in cycle N → `rvalid` no earlier than N+1 → `inst_valid` at N+2 at the earliest.
- With single-cycle memory and no stall: one instruction per cycle.
- Maximum 2 requests outstanding or buffered. The credit check lets the cycle's pop free a slot.
- After redirect at cycle R: `inst_valid`=0 at R+1. First new-path `imem_req` at R+1 if credits allow.

## Test plan
- Reset, 1-cycle memory returning addr as data, no stall → `imem_addr` 0,4,8,…; `inst_valid` from cycle 2; `pc`=`inst`=0,4,8 on consecutive cycles.
- `hazard_stall` for 3 cycles with `occ`=2 → `pc`/`inst` unchanged; `imem_req`=0; after release, entries drain in order with no loss or duplication.
- 3-cycle memory latency, redirect to 32'h0000_0100 with 2 outstanding → both stale responses discarded; next `inst_valid` shows `pc`=0x100.
- Redirect in the same cycle as `imem_ack` and `imem_rvalid` → neither instruction ever appears; `fetch_pc`=`redirect_pc` next cycle.
- Redirect to 32'h0000_0102 → `addr_err`=1, `imem_req`=0 sustained; then aligned redirect to 0x200 → `addr_err`=0, fetch resumes at 0x200.
- `RESET_PC`=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; assert `resetn`=0 mid-stream → `inst_valid`=0 and `imem_req`=0 next cycle.
